// File: rtl/i2c_bit_ctrl.sv
// I2C bit-level controller: turns START/STOP/WRITE/READ commands into four quarter-bit
// phases on open-drain SCL/SDA enables, with optional clock stretching and arbitration check.
module i2c_bit_ctrl #(
    parameter int unsigned CLK_STRETCH = 1
) (
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic       tick_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_i,
    input  logic       din_i,
    output logic       dout_o,
    output logic       dout_valid_o,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe_o,
    output logic       sda_oe_o,
    output logic       busy_o,
    output logic       arb_lost_o
);

    localparam logic [1:0] CmdStart = 2'b00;
    localparam logic [1:0] CmdStop  = 2'b01;
    localparam logic [1:0] CmdWrite = 2'b10;
    localparam logic [1:0] CmdRead  = 2'b11;

    typedef enum logic [2:0] {StIdle, StA, StB, StC, StD} state_e;

    state_e     state_q, state_d;
    logic [1:0] cmd_q, cmd_d;
    logic       din_q, din_d;
    logic       sample_q, sample_d;
    logic       scl_oe_q, scl_oe_d;
    logic       sda_oe_q, sda_oe_d;
    logic       dout_q, dout_d;
    logic       dout_valid_q, dout_valid_d;
    logic       arb_lost_q, arb_lost_d;

    logic       accept;
    logic       lose_arb;
    logic       scl_high;

    // Without stretching the SCL-high phase is purely tick-timed.
    assign scl_high = (CLK_STRETCH == 0) ? 1'b1 : scl_i;

    // State register
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        lose_arb = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    accept  = 1'b1;
                    state_d = StA;
                end
            end
            StA: begin
                if (tick_i) state_d = StB;
            end
            StB: begin
                if (tick_i && scl_high) state_d = StC;
            end
            StC: begin
                if (tick_i) begin
                    // Released SDA read back low while sending a 1: another master owns the bus.
                    if (cmd_q == CmdWrite && din_q && !sda_i) begin
                        lose_arb = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        state_d = StD;
                    end
                end
            end
            StD: begin
                if (tick_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        cmd_d        = accept ? cmd_i : cmd_q;
        din_d        = accept ? din_i : din_q;
        sample_d     = sample_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        arb_lost_d   = lose_arb;
        scl_oe_d     = scl_oe_q;
        sda_oe_d     = sda_oe_q;

        if (state_q == StC && tick_i && cmd_q == CmdRead) begin
            sample_d = sda_i;
        end
        if (state_q == StD && tick_i && cmd_q == CmdRead) begin
            dout_d       = sample_q;
            dout_valid_d = 1'b1;
        end

        // Enables are registered for the state being entered, so they line up with it.
        case (state_d)
            StA: begin
                unique case (cmd_d)
                    CmdStart: {scl_oe_d, sda_oe_d} = 2'b00;
                    CmdStop:  {scl_oe_d, sda_oe_d} = 2'b11;
                    CmdWrite: {scl_oe_d, sda_oe_d} = {1'b1, ~din_d};
                    CmdRead:  {scl_oe_d, sda_oe_d} = 2'b10;
                endcase
            end
            StB: begin
                unique case (cmd_d)
                    CmdStart: {scl_oe_d, sda_oe_d} = 2'b00;
                    CmdStop:  {scl_oe_d, sda_oe_d} = 2'b01;
                    CmdWrite: {scl_oe_d, sda_oe_d} = {1'b0, ~din_d};
                    CmdRead:  {scl_oe_d, sda_oe_d} = 2'b00;
                endcase
            end
            StC: begin
                unique case (cmd_d)
                    CmdStart: {scl_oe_d, sda_oe_d} = 2'b01;
                    CmdStop:  {scl_oe_d, sda_oe_d} = 2'b01;
                    CmdWrite: {scl_oe_d, sda_oe_d} = {1'b0, ~din_d};
                    CmdRead:  {scl_oe_d, sda_oe_d} = 2'b00;
                endcase
            end
            StD: begin
                unique case (cmd_d)
                    CmdStart: {scl_oe_d, sda_oe_d} = 2'b11;
                    CmdStop:  {scl_oe_d, sda_oe_d} = 2'b00;
                    CmdWrite: {scl_oe_d, sda_oe_d} = {1'b1, ~din_d};
                    CmdRead:  {scl_oe_d, sda_oe_d} = 2'b10;
                endcase
            end
            default: begin
                // Idle keeps the last D-phase drive so the bus stays owned between commands.
                if (lose_arb) {scl_oe_d, sda_oe_d} = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cmd_q        <= CmdStart;
            din_q        <= 1'b0;
            sample_q     <= 1'b0;
            scl_oe_q     <= 1'b0;
            sda_oe_q     <= 1'b0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            arb_lost_q   <= 1'b0;
        end else begin
            cmd_q        <= cmd_d;
            din_q        <= din_d;
            sample_q     <= sample_d;
            scl_oe_q     <= scl_oe_d;
            sda_oe_q     <= sda_oe_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            arb_lost_q   <= arb_lost_d;
        end
    end

    assign cmd_ready_o  = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign scl_oe_o     = scl_oe_q;
    assign sda_oe_o     = sda_oe_q;
    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign arb_lost_o   = arb_lost_q;

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Self-checking bench for i2c_bit_ctrl: directed scenarios then randomized commands, checked
// against a phase-table model of the bus enables with an open-drain bus and a scripted slave.
module tb_i2c_bit_ctrl;

    logic       clk = 1'b0;
    logic       arst;
    logic       tick;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic       din;
    logic       dout;
    logic       dout_valid;
    logic       scl, sda;
    logic       scl_oe, sda_oe;
    logic       busy;
    logic       arb_lost;

    logic       slave_scl_low = 1'b0;
    logic       slave_sda_low = 1'b0;

    int         errors = 0;
    int         checks = 0;
    logic       exp_dout = 1'b0;

    // Wired-AND open-drain bus
    assign scl = !scl_oe && !slave_scl_low;
    assign sda = !sda_oe && !slave_sda_low;

    always #5 clk = ~clk;

    i2c_bit_ctrl #(.CLK_STRETCH(1)) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .tick_i       (tick),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_i        (cmd),
        .din_i        (din),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .scl_i        (scl),
        .sda_i        (sda),
        .scl_oe_o     (scl_oe),
        .sda_oe_o     (sda_oe),
        .busy_o       (busy),
        .arb_lost_o   (arb_lost)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {scl_oe, sda_oe} for phase p (0=A..3=D), phases packed A first.
    function automatic logic [1:0] exp_oe(input logic [1:0] c, input logic d, input int p);
        logic [7:0] pat;
        case (c)
            2'b00:   pat = 8'b00_00_01_11;
            2'b01:   pat = 8'b11_01_01_00;
            2'b10:   pat = {1'b1, !d, 1'b0, !d, 1'b0, !d, 1'b1, !d};
            default: pat = 8'b10_00_00_10;
        endcase
        return pat[7-2*p -: 2];
    endfunction

    task automatic check_oe(input string tag, input logic [1:0] oe);
        check({tag, "_scl_oe"}, 8'(scl_oe), 8'(oe[1]));
        check({tag, "_sda_oe"}, 8'(sda_oe), 8'(oe[0]));
    endtask

    task automatic run_cmd(input logic [1:0] c, input logic d, input int stretch,
                           input logic rbit, input logic arb, input logic hold,
                           input logic tick_on_accept);
        logic [1:0] oe;
        check("ready_before", 8'(cmd_ready), 8'd1);
        cmd_valid = 1'b1;
        cmd       = c;
        din       = d;
        tick      = tick_on_accept;
        step();
        tick = 1'b0;
        if (!hold) begin
            cmd_valid = 1'b0;
            cmd       = 2'($urandom_range(0, 3));
            din       = 1'($urandom_range(0, 1));
        end
        for (int p = 0; p < 4; p++) begin
            oe = exp_oe(c, d, p);
            check("busy", 8'(busy), 8'd1);
            check("ready_busy", 8'(cmd_ready), 8'd0);
            check("arb_quiet", 8'(arb_lost), 8'd0);
            check("dv_quiet", 8'(dout_valid), 8'd0);
            check_oe("phase", oe);
            repeat ($urandom_range(0, 2)) begin
                step();
                check_oe("gap", oe);
            end
            if (p == 1) begin
                slave_scl_low = 1'b1;
                repeat (stretch) begin
                    tick = 1'b1;
                    step();
                    tick = 1'b0;
                    check_oe("stretch", oe);
                    check("stretch_busy", 8'(busy), 8'd1);
                end
                slave_scl_low = 1'b0;
            end
            if (p == 2) slave_sda_low = (c == 2'b11) ? !rbit : arb;
            tick = 1'b1;
            step();
            tick          = 1'b0;
            slave_sda_low = 1'b0;
            if (p == 2 && arb) begin
                check("arb_pulse", 8'(arb_lost), 8'd1);
                check_oe("arb", 2'b00);
                check("arb_ready", 8'(cmd_ready), 8'd1);
                step();
                check("arb_pulse_end", 8'(arb_lost), 8'd0);
                check_oe("arb_hold", 2'b00);
                return;
            end
        end
        oe = exp_oe(c, d, 3);
        check("done_ready", 8'(cmd_ready), 8'd1);
        check("done_busy", 8'(busy), 8'd0);
        check("done_arb", 8'(arb_lost), 8'd0);
        check_oe("done", oe);
        if (c == 2'b11) begin
            exp_dout = rbit;
            check("dv_pulse", 8'(dout_valid), 8'd1);
        end else begin
            check("dv_none", 8'(dout_valid), 8'd0);
        end
        check("dout", 8'(dout), 8'(exp_dout));
        if (!hold) begin
            step();
            check("dv_end", 8'(dout_valid), 8'd0);
            check("dout_hold", 8'(dout), 8'(exp_dout));
            check_oe("idle_hold", oe);
        end
    endtask

    initial begin
        arst      = 1'b1;
        tick      = 1'b0;
        cmd_valid = 1'b0;
        cmd       = 2'b00;
        din       = 1'b0;
        #1;
        check("rst_ready", 8'(cmd_ready), 8'd1);
        check("rst_busy", 8'(busy), 8'd0);
        check_oe("rst", 2'b00);
        check("rst_dout", 8'(dout), 8'd0);
        check("rst_dv", 8'(dout_valid), 8'd0);
        check("rst_arb", 8'(arb_lost), 8'd0);
        step();
        step();
        arst = 1'b0;
        step();

        run_cmd(2'b00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);  // START, tick on accept ignored
        run_cmd(2'b10, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // WRITE 0
        run_cmd(2'b11, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);  // READ 1
        run_cmd(2'b11, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // READ 0
        run_cmd(2'b11, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0);  // READ with 5-tick stretch
        run_cmd(2'b10, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);  // WRITE 1, arbitration lost
        run_cmd(2'b00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(2'b10, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);  // valid held through busy
        run_cmd(2'b10, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during C of STOP
        cmd_valid = 1'b1;
        cmd       = 2'b01;
        step();
        cmd_valid = 1'b0;
        tick      = 1'b1;
        step();
        step();
        tick = 1'b0;
        check_oe("stop_c", exp_oe(2'b01, 1'b0, 2));
        #1 arst = 1'b1;
        #1;
        check_oe("mid_rst", 2'b00);
        check("mid_rst_ready", 8'(cmd_ready), 8'd1);
        check("mid_rst_busy", 8'(busy), 8'd0);
        step();
        arst     = 1'b0;
        exp_dout = 1'b0;
        step();
        check("post_rst_dv", 8'(dout_valid), 8'd0);
        check("post_rst_arb", 8'(arb_lost), 8'd0);
        check_oe("post_rst", 2'b00);
        run_cmd(2'b00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] c;
            logic       d;
            logic       a;
            c = 2'($urandom_range(0, 3));
            d = 1'($urandom_range(0, 1));
            a = (c == 2'b10) && d && ($urandom_range(0, 2) == 0);
            run_cmd(c, d, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, 1'b0,
                    1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
